// File: rtl/regfile_sb.sv
// Scoreboarded register file: two combinational read ports, one write port,
// and per-register reservation bits with a live count of pending reservations.
module regfile_sb #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] add1,
  input  logic [ADDR_W-1:0] add2,
  output logic [DATA_W-1:0] read_1,
  output logic [DATA_W-1:0] read_2,
  output logic              busy_1,
  output logic              busy_2,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_add,
  input  logic [DATA_W-1:0] write_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_add,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;
  logic              wr_ok, rsv_ok;

  assign wr_ok  = write_en && (write_add != ZR);
  assign rsv_ok = rsv_en && (rsv_add != ZR);

  // Reservation is applied after the write clear so a same-cycle pair ends busy.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (wr_ok)  mem_d[write_add] = write_data;
    if (wr_ok)  busy_d[write_add] = 1'b0;
    if (rsv_ok) busy_d[rsv_add] = 1'b1;
    busy_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++)
      busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Returns {busy, data}; forwarding a same-cycle write also hides its busy bit.
  function automatic logic [DATA_W:0] rd(input logic [ADDR_W-1:0] a);
    logic [DATA_W:0] r;
    r = '0;
    if (rst || a == ZR)
      r = '0;
    else if ((BYPASS != 0) && wr_ok && (a == write_add))
      r = {1'b0, write_data};
    else
      r = {busy_q[a], mem_q[a]};
    return r;
  endfunction

  assign {busy_1, read_1} = rd(add1);
  assign {busy_2, read_2} = rd(add2);
  assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed plus random checks of regfile_sb against an array-based model,
// with a forwarding and a non-forwarding instance driven in parallel.
module tb_regfile_sb;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int ZR = 31;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] add1, add2, write_add, rsv_add;
  logic          write_en, rsv_en;
  logic [DW-1:0] write_data;
  logic [DW-1:0] r1a, r2a, r1n, r2n;
  logic          b1a, b2a, b1n, b2n;
  logic [AW:0]   cnta, cntn;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] m_mem  [32];
  bit            m_busy [32];

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(ZR), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .add1(add1), .add2(add2), .read_1(r1a), .read_2(r2a),
    .busy_1(b1a), .busy_2(b2a), .write_en(write_en), .write_add(write_add),
    .write_data(write_data), .rsv_en(rsv_en), .rsv_add(rsv_add), .busy_cnt(cnta));

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(ZR), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .add1(add1), .add2(add2), .read_1(r1n), .read_2(r2n),
    .busy_1(b1n), .busy_2(b2n), .write_en(write_en), .write_add(write_add),
    .write_data(write_data), .rsv_en(rsv_en), .rsv_add(rsv_add), .busy_cnt(cntn));

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic bit fwd(input int a, input bit byp);
    return byp && !rst && write_en && int'(write_add) == a && a != ZR;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int a, input bit byp);
    if (rst || a == ZR) return '0;
    if (fwd(a, byp)) return write_data;
    return m_mem[a];
  endfunction

  function automatic logic [DW-1:0] exp_bz(input int a, input bit byp);
    if (rst || a == ZR || fwd(a, byp)) return '0;
    return {63'd0, m_busy[a]};
  endfunction

  function automatic logic [DW-1:0] exp_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return DW'(c);
  endfunction

  task automatic check_all();
    chk("rd1_byp", r1a, exp_rd(int'(add1), 1'b1));
    chk("rd2_byp", r2a, exp_rd(int'(add2), 1'b1));
    chk("bz1_byp", {63'd0, b1a}, exp_bz(int'(add1), 1'b1));
    chk("bz2_byp", {63'd0, b2a}, exp_bz(int'(add2), 1'b1));
    chk("rd1_nb", r1n, exp_rd(int'(add1), 1'b0));
    chk("rd2_nb", r2n, exp_rd(int'(add2), 1'b0));
    chk("bz1_nb", {63'd0, b1n}, exp_bz(int'(add1), 1'b0));
    chk("bz2_nb", {63'd0, b2n}, exp_bz(int'(add2), 1'b0));
    chk("cnt_byp", {58'd0, cnta}, exp_cnt());
    chk("cnt_nb", {58'd0, cntn}, exp_cnt());
  endtask

  task automatic settle();
    #2;
    check_all();
  endtask

  task automatic edge_step();
    @(posedge clk);
    if (!rst) begin
      if (write_en && write_add != ZR) begin
        m_mem[write_add]  = write_data;
        m_busy[write_add] = 1'b0;
      end
      if (rsv_en && rsv_add != ZR) m_busy[rsv_add] = 1'b1;
    end
    #1;
  endtask

  task automatic drive(input bit we, input int wa, input logic [DW-1:0] wd,
                       input bit rv, input int ra, input int a1, input int a2);
    write_en = we; write_add = AW'(wa); write_data = wd;
    rsv_en = rv; rsv_add = AW'(ra); add1 = AW'(a1); add2 = AW'(a2);
  endtask

  task automatic cyc();
    settle();
    edge_step();
  endtask

  initial begin
    rst = 1'b1;
    m_reset();
    // Activity during reset must be ignored and reads forced to zero.
    drive(1, 5, 64'hDEAD, 1, 6, 5, 6);
    settle();
    chk("rst_read", r1a, '0);
    chk("rst_cnt", {58'd0, cnta}, '0);
    edge_step();
    rst = 1'b0;

    drive(1, 5, 64'h1234, 0, 0, 0, 1);
    cyc();
    drive(0, 0, '0, 0, 0, 5, 5);
    settle();
    chk("wr_rd_data", r1a, 64'h1234);
    chk("wr_rd_busy", {63'd0, b1a}, '0);
    edge_step();

    // Zero register discards writes and reservations.
    drive(1, 31, 64'hFFFF, 1, 31, 31, 31);
    settle();
    chk("xzr_rd_same", r1a, '0);
    edge_step();
    drive(0, 0, '0, 0, 0, 31, 31);
    settle();
    chk("xzr_rd_after", r1a, '0);
    chk("xzr_cnt", {58'd0, cnta}, '0);
    edge_step();

    drive(1, 7, 64'h11, 0, 0, 0, 0);
    cyc();
    drive(1, 7, 64'hAA, 0, 0, 0, 7);
    settle();
    chk("byp_fwd", r2a, 64'hAA);
    chk("byp_off_old", r2n, 64'h11);
    edge_step();

    drive(0, 0, '0, 1, 3, 3, 4);
    cyc();
    drive(0, 0, '0, 1, 4, 3, 4);
    cyc();
    drive(0, 0, '0, 1, 3, 3, 4);
    settle();
    chk("sb_cnt2", {58'd0, cnta}, 64'd2);
    edge_step();
    drive(1, 3, 64'h33, 0, 0, 3, 4);
    settle();
    chk("sb_rersv_cnt", {58'd0, cnta}, 64'd2);
    edge_step();
    drive(1, 4, 64'h77, 1, 4, 3, 4);
    settle();
    chk("sb_wr_cnt1", {58'd0, cnta}, 64'd1);
    chk("sb_wr_busy", {63'd0, b1a}, '0);
    edge_step();
    drive(0, 0, '0, 0, 0, 4, 3);
    settle();
    chk("sb_rsvwin_cnt", {58'd0, cnta}, 64'd1);
    chk("sb_rsvwin_data", r1a, 64'h77);
    chk("sb_rsvwin_busy", {63'd0, b1a}, 64'd1);
    edge_step();

    // Random traffic; small address pool most of the time to force collisions.
    for (int n = 0; n < 400; n++) begin
      int wa, ra, a1, a2;
      wa = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
      ra = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? ra : int'($urandom_range(0, 7));
      drive(bit'($urandom_range(0, 1)), wa, {$urandom, $urandom},
            bit'($urandom_range(0, 1)), ra, a1, a2);
      cyc();
    end

    // Async reset between edges, then rebuild a known state and reset again.
    rst = 1'b1;
    m_reset();
    #1;
    rst = 1'b0;
    drive(1, 9, 64'h55, 1, 1, 9, 1);
    cyc();
    drive(0, 0, '0, 1, 2, 9, 2);
    cyc();
    drive(0, 0, '0, 1, 3, 9, 3);
    cyc();
    drive(0, 0, '0, 0, 0, 9, 3);
    settle();
    chk("pre_rst_r9", r1a, 64'h55);
    chk("pre_rst_cnt", {58'd0, cnta}, 64'd3);
    #1;
    rst = 1'b1;
    m_reset();
    #1;
    chk("async_rst_r9", r1a, '0);
    chk("async_rst_cnt", {58'd0, cnta}, '0);
    check_all();
    edge_step();
    rst = 1'b0;
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
